// File: rtl/hwa_fir_sequencer.sv
// ============================================================================
// hwa_fir_sequencer : window sequencer and lane ones-counter for the SC FIR
// Revision: 1.0
// ============================================================================
`default_nettype none

module hwa_fir_sequencer #(
  parameter int N       = 12,
  parameter int LENGTH  = 19,
  parameter int LEN_IDX = 5,
  parameter int LANES   = 4,
  parameter int DP_LAT  = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N:0]               in_data,
  output logic                     dp_start,
  output logic [N:0]               dp_sample,
  output logic [N-1:0]             sel_bits,
  output logic [LEN_IDX-1:0]       idx,
  input  logic [LANES-1:0]         dp_bits,
  output logic [(N+1)*LANES-1:0]   result,
  output logic                     result_valid,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  localparam logic [LEN_IDX-1:0] IDX_LAST   = LEN_IDX'(LENGTH - 1);
  localparam logic [1:0]         DRAIN_LAST = (DP_LAT > 0) ? 2'(DP_LAT - 1) : 2'd0;

  state_t                   state;
  logic                     stop_seen;
  logic [1:0]               drain_cnt;
  logic                     run_d;
  logic                     first_d;
  logic [N:0]               acc      [LANES];
  logic [N:0]               acc_next [LANES];
  logic [(N+1)*LANES-1:0]   acc_flat;

  // Sampling window is the RUN window shifted by the datapath latency.
  generate
    if (DP_LAT == 0) begin : g_lat_zero
      assign run_d   = (state == RUN);
      assign first_d = dp_start;
    end else begin : g_lat_pipe
      logic [DP_LAT-1:0] run_sr;
      logic [DP_LAT-1:0] first_sr;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          run_sr   <= '0;
          first_sr <= '0;
        end else begin
          for (int i = DP_LAT - 1; i > 0; i--) begin
            run_sr[i]   <= run_sr[i-1];
            first_sr[i] <= first_sr[i-1];
          end
          run_sr[0]   <= (state == RUN);
          first_sr[0] <= dp_start;
        end
      end
      assign run_d   = run_sr[DP_LAT-1];
      assign first_d = first_sr[DP_LAT-1];
    end
  endgenerate

  always_comb begin
    acc_flat = '0;
    for (int k = 0; k < LANES; k++) begin
      acc_next[k] = first_d ? {{N{1'b0}}, dp_bits[k]}
                            : acc[k] + {{N{1'b0}}, dp_bits[k]};
      acc_flat[k*(N+1) +: N+1] = acc_next[k];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      stop_seen    <= 1'b0;
      drain_cnt    <= '0;
      in_ready     <= 1'b0;
      dp_start     <= 1'b0;
      dp_sample    <= '0;
      sel_bits     <= '0;
      idx          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      for (int k = 0; k < LANES; k++) acc[k] <= '0;
    end else begin
      dp_start     <= 1'b0;
      result_valid <= 1'b0;
      if (run_d) begin
        for (int k = 0; k < LANES; k++) acc[k] <= acc_next[k];
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            state     <= RUN;
            in_ready  <= 1'b0;
            dp_sample <= in_data;
            dp_start  <= 1'b1;
            sel_bits  <= '0;
            idx       <= '0;
            stop_seen <= 1'b0;
          end else if (stop) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        end
        RUN: begin
          if (stop) stop_seen <= 1'b1;
          if (sel_bits == '1) begin
            sel_bits <= '0;
            idx      <= '0;
            if (DP_LAT == 0) begin
              state        <= DONE;
              result       <= acc_flat;
              result_valid <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            sel_bits <= sel_bits + 1'b1;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
        end
        DRAIN: begin
          if (stop) stop_seen <= 1'b1;
          // The last sampled cycle coincides with the final DRAIN cycle.
          if (drain_cnt == DRAIN_LAST) begin
            state        <= DONE;
            result       <= acc_flat;
            result_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          if (stop_seen) begin
            state     <= IDLE;
            busy      <= 1'b0;
            stop_seen <= 1'b0;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hwa_fir_sequencer.sv
// ============================================================================
// tb_hwa_fir_sequencer : scoreboard bench for the SC FIR window sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hwa_fir_sequencer;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         in_valid = 1'b0;
  logic [12:0]  in_data = '0;
  logic [3:0]   dp_bits = '0;
  logic         in_ready;
  logic         dp_start;
  logic [12:0]  dp_sample;
  logic [11:0]  sel_bits;
  logic [4:0]   idx;
  logic [51:0]  result;
  logic         result_valid;
  logic         busy;

  hwa_fir_sequencer #(.N(12), .LENGTH(19), .LEN_IDX(5), .LANES(4), .DP_LAT(1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_start(dp_start), .dp_sample(dp_sample), .sel_bits(sel_bits), .idx(idx),
    .dp_bits(dp_bits), .result(result), .result_valid(result_valid), .busy(busy)
  );

  typedef struct {
    logic [51:0] res;
    logic [12:0] smp;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          rv_cycles[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mode = 0;
  logic [11:0] prev_sel = '0;

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand-computed lane counts: full-scale = 4096 each; mixed = 0,2048,4096,1024.
  function automatic logic [51:0] exp_res(input int m);
    if (m == 0) return {13'd4096, 13'd4096, 13'd4096, 13'd4096};
    return {13'd1024, 13'd4096, 13'd2048, 13'd0};
  endfunction

  // Datapath stand-in with one cycle of latency.
  initial forever begin
    @(negedge clock);
    dp_bits  = (mode == 0) ? 4'hF : {prev_sel[0] & prev_sel[1], 1'b1, prev_sel[0], 1'b0};
    prev_sel = sel_bits;
  end

  initial begin : monitor
    int   run_k;
    int   seq_bad;
    exp_t e;
    run_k = -1;
    seq_bad = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        run_k = -1;
        continue;
      end
      if (in_valid && in_ready)
        sb.push_back('{exp_res(mode), in_data, cyc + 4098});
      if (result_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result_valid: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("dp_sample", dp_sample, e.smp);
          chk("rv_cycle", cyc, e.cyc);
          rv_cycles.push_back(cyc);
        end
      end
      if (dp_start && run_k < 0) begin
        run_k = 0;
        seq_bad = 0;
      end
      if (run_k >= 0) begin
        if (sel_bits !== 12'(run_k) || idx !== 5'(run_k % 19) || dp_start !== (run_k == 0))
          seq_bad++;
        if (run_k == 4095) begin
          chk("idx_last", idx, 10);
          chk("seq_bad_cycles", seq_bad, 0);
          run_k = -1;
        end else begin
          run_k++;
        end
      end
    end
  end

  task automatic chk_zero();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_dp_sample", dp_sample, 0);
    chk("rst_sel_bits", sel_bits, 0);
    chk("rst_idx", idx, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clock); #1 stop = 1'b1;
    @(posedge clock); #1 stop = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("handshake_seen", ok, 1);
  endtask

  task automatic send(input logic [12:0] d);
    bit ok;
    @(posedge clock); #1;
    in_data  = d;
    in_valid = 1'b1;
    wait_ready(ok);
    @(posedge clock); #1 in_valid = 1'b0;
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 10000; i++) begin
      if (sb.size() == 0) return;
      @(posedge clock); #2;
    end
    checks++;
    errors++;
    $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
  endtask

  initial begin : stim
    int          cnt;
    bit          ok;
    logic [12:0] smp[3];
    smp = '{13'd3, 13'd7, 13'd11};

    #1 chk_zero();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);

    // Full-scale window.
    mode = 0;
    pulse_start();
    send(13'd3);
    wait_sb();

    // Mixed lanes, with a start pulse mid-window.
    mode = 1;
    send(13'd5);
    repeat (50) @(posedge clock);
    pulse_start();
    wait_sb();

    // Stop during RUN: window completes, then IDLE.
    mode = 0;
    send(13'd9);
    repeat (100) @(posedge clock);
    pulse_stop();
    wait_sb();
    chk("stop_run_busy", busy, 0);
    chk("stop_run_in_ready", in_ready, 0);
    in_valid = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (in_ready) cnt++;
    end
    chk("ready_after_stop", cnt, 0);
    in_valid = 1'b0;

    // Stop in LOAD.
    pulse_start();
    chk("load_in_ready", in_ready, 1);
    stop = 1'b1;
    @(posedge clock); #1 stop = 1'b0;
    chk("stop_load_busy", busy, 0);
    chk("stop_load_in_ready", in_ready, 0);

    // Start and stop together in IDLE: start wins.
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_in_ready", in_ready, 1);
    chk("start_stop_busy", busy, 1);

    // Back-to-back with in_valid held high.
    mode = 1;
    rv_cycles.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = smp[i];
      wait_ready(ok);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    pulse_stop();
    wait_sb();
    chk("b2b_count", rv_cycles.size(), 3);
    if (rv_cycles.size() == 3) begin
      chk("b2b_gap0", rv_cycles[1] - rv_cycles[0], 4099);
      chk("b2b_gap1", rv_cycles[2] - rv_cycles[1], 4099);
    end
    @(posedge clock); #1;
    chk("b2b_end_busy", busy, 0);

    // Reset mid-RUN aborts the window.
    pulse_start();
    send(13'd7);
    repeat (100) @(posedge clock);
    #3 reset_n = 1'b0;
    #1 chk_zero();
    sb.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (4300) @(posedge clock);
    #1;
    chk("abort_result", result, 0);
    chk("abort_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
